bram_mem_ctrl: RTL

- Single-clock load/store front end between the CPU datapath and port A of the team's dual-port 16-bit block RAM.
- Accepts one request at a time over a valid/ready handshake and decodes the 16-bit address into three regions: BRAM, memory-mapped I/O (LED register, switch input), or illegal.
- Sequences the BRAM's one-cycle registered read latency and returns read data or a write acknowledge as a one-cycle response pulse.

---
 rtl/mem_ctrl_pkg.sv | 19 +
 rtl/bram_mem_ctrl_sync_2ff.sv | 23 ++
 rtl/bram_mem_ctrl.sv | 129 ++++++++++++
 3 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared decode constants and encodings for the BRAM load/store controller.
package mem_ctrl_pkg;

  localparam logic [15:0] LED_ADDR_DEF = 16'hFFF0;
  localparam logic [15:0] SW_ADDR_DEF  = 16'hFFF1;

  typedef enum logic {
    IDLE,
    RD_WAIT
  } state_t;

  typedef enum logic [1:0] {
    REG_BRAM,
    REG_LED,
    REG_SW,
    REG_ERR
  } region_t;

endpackage

// File: rtl/bram_mem_ctrl_sync_2ff.sv
// Two-flop synchroniser for a bus of quasi-static asynchronous inputs.
module sync_2ff #(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_p0;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_p0 <= '0;
      q       <= '0;
    end else begin
      meta_p0 <= d;
      q       <= meta_p0;
    end
  end

endmodule

// File: rtl/bram_mem_ctrl.sv
// Load/store front end: decodes CPU requests into BRAM, LED/switch I/O or error,
// and turns each accepted request into a single-cycle response pulse.
module bram_mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int          DATA_WIDTH = 16,
  parameter int          ADDR_WIDTH = 10,
  parameter logic [15:0] LED_ADDR   = LED_ADDR_DEF,
  parameter logic [15:0] SW_ADDR    = SW_ADDR_DEF,
  parameter int          IO_WIDTH   = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [15:0]           req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic [DATA_WIDTH-1:0] bram_data,
  output logic                  bram_we,
  input  logic [DATA_WIDTH-1:0] bram_q,
  input  logic [IO_WIDTH-1:0]   sw_in,
  output logic [IO_WIDTH-1:0]   led_out
);

  localparam int PAD_W = DATA_WIDTH - IO_WIDTH;

  state_t                state, state_next;
  region_t               region;
  logic                  accept;
  logic [ADDR_WIDTH-1:0] rd_addr_p0;
  logic [IO_WIDTH-1:0]   sw_sync;

  sync_2ff #(
    .WIDTH(IO_WIDTH)
  ) u_sw_sync (
    .clk  (clk),
    .reset(reset),
    .d    (sw_in),
    .q    (sw_sync)
  );

  always_comb begin
    region = REG_ERR;
    if (req_addr[15:ADDR_WIDTH] == '0) begin
      region = REG_BRAM;
    end else if (req_addr == LED_ADDR) begin
      region = REG_LED;
    end else if (req_addr == SW_ADDR) begin
      region = REG_SW;
    end
  end

  assign req_ready = (state == IDLE) && !reset;
  assign accept    = req_valid && req_ready;

  // In RD_WAIT the BRAM keeps seeing the load address so q_a stays coherent.
  assign bram_addr = (state == IDLE) ? req_addr[ADDR_WIDTH-1:0] : rd_addr_p0;
  assign bram_data = req_wdata;
  assign bram_we   = (state == IDLE) && req_valid && req_we && (region == REG_BRAM) && !reset;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept && !req_we && (region == REG_BRAM)) state_next = RD_WAIT;
      RD_WAIT: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (accept && !req_we && (region == REG_BRAM)) begin
      rd_addr_p0 <= req_addr[ADDR_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      led_out   <= '0;
    end else begin
      state     <= state_next;
      rsp_valid <= 1'b0;
      if (state == RD_WAIT) begin
        rsp_valid <= 1'b1;
        rsp_rdata <= bram_q;
        rsp_err   <= 1'b0;
      end else if (accept) begin
        case (region)
          REG_BRAM: begin
            if (req_we) begin
              rsp_valid <= 1'b1;
              rsp_rdata <= '0;
              rsp_err   <= 1'b0;
            end
          end
          REG_LED: begin
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            if (req_we) begin
              led_out   <= req_wdata[IO_WIDTH-1:0];
              rsp_rdata <= '0;
            end else begin
              rsp_rdata <= {{PAD_W{1'b0}}, led_out};
            end
          end
          REG_SW: begin
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_rdata <= req_we ? '0 : {{PAD_W{1'b0}}, sw_sync};
          end
          default: begin
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
          end
        endcase
      end
    end
  end

endmodule
